demux_rr_ctrl: RTL and testbench

DEMUX_RR_CTRL -- requirements
Module: demux_rr_ctrl

---
 rtl/demux_rr_ctrl.sv | 116 +++++++++++
 tb/tb_demux_rr_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_rr_ctrl.sv
// Round-robin scheduler steering one source stream to four destinations.
// Grants a destination for up to BURST beats or until the packet's last word.
module demux_rr_ctrl #(
   parameter int DW    = 8,
   parameter int BURST = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [3:0]    dest_en,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          in_ready,
   input  logic [3:0]    out_ready,
   output logic [3:0]    out_valid,
   output logic [DW-1:0] out_data,
   output logic [1:0]    sel,
   output logic          busy,
   output logic [15:0]   word_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEEK = 2'd1,
      XFER = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic [7:0]  beat_q, beat_d;
   logic [15:0] wcnt_q, wcnt_d;
   logic        fresh_q, fresh_d;
   logic [1:0]  start;
   logic [1:0]  pick;
   logic        beat;
   logic        burst_end;

   assign beat      = (state_q == XFER) & in_valid & out_ready[sel_q];
   assign burst_end = beat & (in_last | (beat_q == 8'(BURST - 1)));

   // fresh_q forces the first scan after reset to begin at destination 0
   assign start = fresh_q ? 2'd0 : sel_q + 2'd1;

   always_comb begin
      pick = start;
      for (int k = 3; k >= 0; k--) begin
         if (dest_en[start + 2'(k)]) begin
            pick = start + 2'(k);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= 2'd0;
         beat_q  <= 8'd0;
         wcnt_q  <= 16'd0;
         fresh_q <= 1'b1;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         beat_q  <= beat_d;
         wcnt_q  <= wcnt_d;
         fresh_q <= fresh_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      beat_d  = beat_q;
      wcnt_d  = wcnt_q;
      fresh_d = fresh_q;
      unique case (state_q)
         IDLE: begin
            if (en) state_d = SEEK;
         end
         SEEK: begin
            if (!en) begin
               state_d = IDLE;
            end else if (|dest_en) begin
               state_d = XFER;
               sel_d   = pick;
               beat_d  = 8'd0;
               fresh_d = 1'b0;
            end
         end
         XFER: begin
            if (beat) begin
               beat_d = beat_q + 8'd1;
               wcnt_d = wcnt_q + 16'd1;
               if (burst_end) state_d = en ? SEEK : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 4'b0000;
      out_data  = in_data;
      busy      = 1'b0;
      if (state_q == XFER) begin
         in_ready         = out_ready[sel_q];
         out_valid[sel_q] = in_valid;
         busy             = 1'b1;
      end
   end

   assign sel      = sel_q;
   assign word_cnt = wcnt_q;

endmodule

// File: tb/tb_demux_rr_ctrl.sv
// Directed bench for demux_rr_ctrl with BURST=4.
// Outputs are sampled 2 time units after each rising edge.
module tb_demux_rr_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [3:0]  dest_en;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        in_ready;
   logic [3:0]  out_ready;
   logic [3:0]  out_valid;
   logic [7:0]  out_data;
   logic [1:0]  sel;
   logic        busy;
   logic [15:0] word_cnt;

   int total = 0;
   int bad   = 0;

   demux_rr_ctrl #(.DW(8), .BURST(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .dest_en   (dest_en),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .sel       (sel),
      .busy      (busy),
      .word_cnt  (word_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      en        = 1'b0;
      dest_en   = 4'h0;
      in_valid  = 1'b0;
      in_data   = 8'h5A;
      in_last   = 1'b0;
      out_ready = 4'h0;
      tick();
      tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_sel", 32'(sel), 0);
      chk("rst_wc", 32'(word_cnt), 0);
      chk("rst_rdy", 32'(in_ready), 0);
      chk("rst_ov", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 32'h5A);

      // four full bursts over all destinations
      rst_n     = 1'b1;
      en        = 1'b1;
      dest_en   = 4'hF;
      out_ready = 4'hF;
      in_valid  = 1'b1;
      for (int b = 0; b < 4; b++) begin
         tick();
         chk("seek_busy", 32'(busy), 0);
         chk("seek_rdy", 32'(in_ready), 0);
         tick();
         chk("rr_sel", 32'(sel), 32'(b));
         chk("rr_ov", 32'(out_valid), 32'(1 << b));
         chk("rr_wc", 32'(word_cnt), 32'(4 * b));
         repeat (3) begin
            tick();
            chk("rr_busy", 32'(busy), 1);
         end
      end
      tick();
      chk("rr_wc16", 32'(word_cnt), 16);
      chk("rr_gap", 32'(busy), 0);
      tick();
      chk("rr_wrap_sel", 32'(sel), 0);
      in_data = 8'hC3;
      #1;
      chk("xfer_data", 32'(out_data), 32'hC3);

      // in_last on the second beat
      tick();
      in_last = 1'b1;
      tick();
      in_last = 1'b0;
      chk("last_busy", 32'(busy), 0);
      chk("last_wc", 32'(word_cnt), 18);
      tick();
      chk("last_sel", 32'(sel), 1);
      repeat (3) tick();
      chk("last_full", 32'(busy), 1);
      tick();
      chk("last_end", 32'(busy), 0);
      chk("last_wc2", 32'(word_cnt), 22);
      tick();
      chk("stall_sel", 32'(sel), 2);

      // stall destination 2 for five cycles
      tick();
      out_ready = 4'hB;
      #1;
      chk("stall_rdy", 32'(in_ready), 0);
      repeat (5) begin
         tick();
         chk("stall_busy", 32'(busy), 1);
         chk("stall_wc", 32'(word_cnt), 23);
         chk("stall_ov", 32'(out_valid), 32'h4);
      end
      out_ready = 4'hF;
      tick();
      tick();
      chk("resume_busy", 32'(busy), 1);
      chk("resume_wc", 32'(word_cnt), 25);
      tick();
      chk("resume_end", 32'(busy), 0);
      chk("resume_wc2", 32'(word_cnt), 26);
      tick();
      chk("rst_mid_sel", 32'(sel), 3);

      // reset on beat 2 of the sel=3 burst
      tick();
      rst_n = 1'b0;
      tick();
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_sel", 32'(sel), 0);
      chk("mrst_wc", 32'(word_cnt), 0);
      chk("mrst_ov", 32'(out_valid), 0);
      chk("mrst_rdy", 32'(in_ready), 0);
      rst_n = 1'b1;
      tick();
      chk("mrst_seek", 32'(busy), 0);
      tick();
      chk("mrst_first", 32'(sel), 0);
      chk("mrst_xfer", 32'(busy), 1);

      // en dropped on beat 1
      en = 1'b0;
      tick();
      tick();
      tick();
      chk("endrop_busy", 32'(busy), 1);
      chk("endrop_wc", 32'(word_cnt), 3);
      tick();
      chk("endrop_idle", 32'(busy), 0);
      chk("endrop_rdy", 32'(in_ready), 0);
      chk("endrop_ov", 32'(out_valid), 0);
      chk("endrop_wc2", 32'(word_cnt), 4);
      tick();
      chk("endrop_stay", 32'(busy), 0);

      // sparse mask 1010
      en      = 1'b1;
      dest_en = 4'hA;
      tick();
      for (int g = 0; g < 3; g++) begin
         tick();
         chk("mask_sel", 32'(sel), (g == 1) ? 3 : 1);
         for (int k = 0; k < 4; k++) begin
            chk("mask_ov02", 32'(out_valid & 4'h5), 0);
            chk("mask_busy", 32'(busy), 1);
            tick();
         end
      end

      // empty mask holds SEEK, then en=0 returns to IDLE
      dest_en = 4'h0;
      tick();
      chk("nomask_busy", 32'(busy), 0);
      chk("nomask_sel", 32'(sel), 1);
      tick();
      chk("nomask_stay", 32'(busy), 0);
      en = 1'b0;
      tick();
      en      = 1'b1;
      dest_en = 4'hF;
      tick();
      chk("idle_seek", 32'(busy), 0);
      tick();
      chk("idle_sel", 32'(sel), 2);
      chk("idle_busy", 32'(busy), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
